ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter PC_W, default 6, meaning program-counter width in bits (4..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port mem_rdata  input  9  instruction word from program memory: [8:6] opcode, [5:3] RX, [2:0] RY.
REQ-005 SHALL have port mem_ack  input  1  program memory has valid data on mem_rdata this cycle.
REQ-006 SHALL have port alu_zero  input  1  ALU result-zero flag, sampled in EXEC.
REQ-007 SHALL have port mem_req  output  1  instruction fetch request.
REQ-008 SHALL have port pc  output  PC_W  current program counter, the fetch address.
REQ-009 SHALL have port alu_op  output  3  opcode driven to the ALU.
REQ-010 SHALL have port rx_sel  output  3  destination/first-source register index.
REQ-011 SHALL have port ry_sel  output  3  second-source register index.
REQ-012 SHALL have port reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 SHALL have port halted  output  1  high while in HALT.

Function
REQ-014 SHALL implement the FSM states FETCH, DECODE, EXEC, WB and HALT, with FETCH as the reset state.
REQ-015 FETCH: mem_req=1 and pc held; on mem_ack=1, latch mem_rdata into the 9-bit IR and go to DECODE; otherwise stay in FETCH, with no timeout.
REQ-016 mem_req SHALL drop in the cycle after mem_ack is sampled, and any mem_ack outside FETCH SHALL be ignored.
REQ-017 DECODE: split IR into alu_op=IR[8:6], rx_sel=IR[5:3] and ry_sel=IR[2:0], registered, then go to EXEC; these outputs hold until the next DECODE.
REQ-018 EXEC for opcodes 000-101 (MOV, ADD, SUB, AND, OR, LDI) SHALL go to WB.
REQ-019 EXEC for opcode 110 (JNZ): if alu_zero=0, pc <= {RX,RY} zero-extended or truncated to PC_W; else pc <= pc+1; next state FETCH, with no reg_we.
REQ-020 EXEC for opcode 111 (HALT) SHALL go to HALT with pc unchanged.
REQ-021 WB SHALL pulse reg_we=1 for exactly one cycle, set pc <= pc+1, and go to FETCH.
REQ-022 pc increment SHALL wrap modulo 2^PC_W: the all-ones value goes to 0.
REQ-023 HALT SHALL be absorbing, leaving it only by reset, with mem_req=0, reg_we=0 and halted=1.
REQ-024 Instruction latency without wait states SHALL be 4 cycles for ALU ops, 3 for JNZ and 3 to reach HALT; each cycle mem_ack is late adds one cycle.

Reset
REQ-025 On rst=1, immediately and independently of clk: state=FETCH, pc=0, IR=0, alu_op=0, rx_sel=0, ry_sel=0, reg_we=0, halted=0, and mem_req=0 while rst is asserted.
REQ-026 Reset mid-instruction SHALL abort it without any reg_we pulse, and the first cycle after release SHALL be FETCH with mem_req=1 and pc=0.

Configuration
REQ-027 Macro CTRL_SINGLE_STEP_EN defined SHALL add input port step (1 bit); FETCH asserts mem_req only after a step=1 pulse has been latched, the latch is cleared on mem_ack, and a step arriving outside FETCH is held for the next FETCH.
REQ-028 Macro CTRL_SINGLE_STEP_EN undefined SHALL leave no step port, with FETCH asserting mem_req unconditionally.

Verification
REQ-029 Reset then mem_rdata=9'b001_010_011 with mem_ack=1 every cycle -> reg_we pulses in cycle 4, alu_op=001, rx_sel=2, ry_sel=3, and pc goes 0->1.
REQ-030 JNZ 9'b110_000_101 at pc=0 with alu_zero=0 -> pc=5 and no reg_we; repeated with alu_zero=1 -> pc=1.
REQ-031 mem_ack delayed 3 cycles -> mem_req held high 4 cycles, with pc and IR stable until ack.
REQ-032 PC_W=4, pc=15, ADD executed -> pc wraps to 0.
REQ-033 HALT 9'b111_000_000 -> halted=1 and mem_req=0 for 20 cycles; rst asserted for 1 cycle -> FETCH with pc=0.
REQ-034 rst asserted during WB -> no reg_we pulse, all outputs at reset values asynchronously; with CTRL_SINGLE_STEP_EN, no fetch occurs until step=1.

Source files
------------

// File: rtl/ctrl_unit.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (WB) -> FETCH, with an absorbing HALT.
// Optional single-step fetch gating is enabled by defining CTRL_SINGLE_STEP_EN.
module ctrl_unit #(
    parameter int unsigned PC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [8:0]      mem_rdata,
    input  logic            mem_ack,
    input  logic            alu_zero,
    output logic            mem_req,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_op,
    output logic [2:0]      rx_sel,
    output logic [2:0]      ry_sel,
    output logic            reg_we,
    output logic            halted
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

    localparam logic [2:0] OpJnz  = 3'b110;
    localparam logic [2:0] OpHalt = 3'b111;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, jump_tgt;
    logic [8:0]        ir_q, ir_d;
    logic [2:0]        op_q, op_d, rx_q, rx_d, ry_q, ry_d;
    logic              step_ok, fetch_req, fetch_go;

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q, step_d;

    // A step seen outside FETCH stays pending until the next fetch is accepted.
    always_comb begin
        step_d = step_q;
        if (fetch_go) step_d = 1'b0;
        if (step)     step_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step_d;
    end

    assign step_ok = step_q;
`else
    assign step_ok = 1'b1;
`endif

    assign fetch_req = (state_q == StFetch) && step_ok;
    assign fetch_go  = fetch_req && mem_ack;
    assign pc_inc    = pc_q + PC_W'(1);
    assign jump_tgt  = PC_W'({rx_q, ry_q});

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        op_d    = op_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        unique case (state_q)
            StFetch: begin
                if (fetch_go) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_d    = ir_q[8:6];
                rx_d    = ir_q[5:3];
                ry_d    = ir_q[2:0];
                state_d = StExec;
            end
            StExec: begin
                if (op_q == OpJnz) begin
                    pc_d    = alu_zero ? pc_inc : jump_tgt;
                    state_d = StFetch;
                end else if (op_q == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_d    = pc_inc;
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            op_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    // Reset leaves the state in FETCH, so the request is masked while rst is high.
    assign mem_req = fetch_req && !rst;
    assign pc      = pc_q;
    assign alu_op  = op_q;
    assign rx_sel  = rx_q;
    assign ry_sel  = ry_q;
    assign reg_we  = (state_q == StWb);
    assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_ctrl_unit.sv
// Randomized bench for ctrl_unit: a per-instruction model predicts pc, decoded fields and per-cycle
// mem_req/reg_we/halted for two instances (PC_W=6 and PC_W=4) driven by the same stimulus.
module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;
    logic       alu_zero = 1'b0;

    logic       req6, we6, hlt6, req4, we4, hlt4;
    logic [5:0] pc6;
    logic [3:0] pc4;
    logic [2:0] op6, rx6, ry6, op4, rx4, ry4;

    ctrl_unit dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .mem_req(req6), .pc(pc6), .alu_op(op6), .rx_sel(rx6), .ry_sel(ry6),
        .reg_we(we6), .halted(hlt6)
    );

    ctrl_unit #(.PC_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .mem_req(req4), .pc(pc4), .alu_op(op4), .rx_sel(rx4), .ry_sel(ry4),
        .reg_we(we4), .halted(hlt4)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned mpc6 = 0;
    int unsigned mpc4 = 0;
    logic [8:0]  last_ir = '0;

    function automatic logic [33:0] observe();
        return {req6, we6, hlt6, op6, rx6, ry6, pc6, req4, we4, hlt4, op4, rx4, ry4, pc4};
    endfunction

    function automatic logic [33:0] expect_vec(logic req, logic we, logic hlt);
        logic [5:0] p6;
        logic [3:0] p4;
        p6 = 6'(mpc6);
        p4 = 4'(mpc4);
        return {req, we, hlt, last_ir, p6, req, we, hlt, last_ir, p4};
    endfunction

    // Called at a negedge with both DUTs in FETCH; returns at the negedge after the instruction.
    task automatic run_instr(input logic [8:0] instr, input int delay, input logic zero,
                             input string tag);
        logic [33:0] e, o;
        int          post;
        logic [2:0]  op;
        op = instr[8:6];
        alu_zero = zero;
        for (int i = 0; i <= delay; i++) begin
            e = expect_vec(1'b1, 1'b0, 1'b0);
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s fetch cyc%0d: got %h expected %h", tag, i, o, e);
            end
            mem_ack   = (i == delay);
            mem_rdata = (i == delay) ? instr : 9'($urandom);
            @(negedge clk);
        end
        post = (op >= 3'd6) ? 2 : 3;
        for (int k = 1; k <= post; k++) begin
            if (k == 2) last_ir = instr;
            e = expect_vec(1'b0, (op < 3'd6) && (k == 3), 1'b0);
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s step%0d: got %h expected %h", tag, k, o, e);
            end
            mem_ack   = 1'($urandom);
            mem_rdata = 9'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        if (op < 3'd6 || (op == 3'd6 && zero)) begin
            mpc6 = (mpc6 + 1) % 64;
            mpc4 = (mpc4 + 1) % 16;
        end else if (op == 3'd6) begin
            mpc6 = instr[5:0] % 64;
            mpc4 = instr[5:0] % 16;
        end
    endtask

    // Asserts rst at a negedge, checks the asynchronous effect, releases on the next negedge.
    task automatic do_reset(input string tag);
        logic [33:0] e, o;
        rst = 1'b1;
        mem_ack = 1'b0;
        mpc6 = 0;
        mpc4 = 0;
        last_ir = '0;
        #1;
        e = expect_vec(1'b0, 1'b0, 1'b0);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s async: got %h expected %h", tag, o, e);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        e = expect_vec(1'b1, 1'b0, 1'b0);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s release: got %h expected %h", tag, o, e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        do_reset("reset");
    endtask

    task automatic test_alu_basic();
        run_instr(9'b001_010_011, 0, 1'b0, "add_basic");
        run_instr(9'b000_111_001, 0, 1'b1, "mov_basic");
    endtask

    task automatic test_jnz();
        do_reset("jnz_rst_a");
        run_instr(9'b110_000_101, 0, 1'b0, "jnz_taken");
        run_instr(9'b101_001_001, 0, 1'b0, "ldi_after_jnz");
        do_reset("jnz_rst_b");
        run_instr(9'b110_000_101, 0, 1'b1, "jnz_not_taken");
        run_instr(9'b100_000_000, 0, 1'b0, "or_after_jnz");
    endtask

    task automatic test_wait_states();
        run_instr(9'b010_100_110, 3, 1'b0, "ack_delay3");
        run_instr(9'b110_011_000, 2, 1'b0, "jnz_delay2");
    endtask

    task automatic test_wrap();
        do_reset("wrap_rst");
        run_instr(9'b110_001_111, 0, 1'b0, "jnz_to_15");
        run_instr(9'b001_001_001, 1, 1'b0, "add_wrap");
        run_instr(9'b011_000_001, 0, 1'b0, "and_after_wrap");
    endtask

    task automatic test_back_to_back();
        logic [8:0] instr;
        for (int n = 0; n < 60; n++) begin
            instr = 9'($urandom);
            if (instr[8:6] == 3'b111) instr[8:6] = 3'($urandom_range(0, 6));
            run_instr(instr, int'($urandom_range(0, 3)), 1'($urandom), "random");
        end
    endtask

    task automatic test_halt();
        logic [33:0] e, o;
        run_instr(9'b111_000_000, 1, 1'b0, "halt_enter");
        for (int i = 0; i < 20; i++) begin
            e = expect_vec(1'b0, 1'b0, 1'b1);
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt_hold cyc%0d: got %h expected %h", i, o, e);
            end
            mem_ack   = 1'($urandom);
            mem_rdata = 9'($urandom);
            alu_zero  = 1'($urandom);
            @(negedge clk);
        end
        do_reset("halt_exit");
        run_instr(9'b001_010_011, 0, 1'b0, "after_halt");
    endtask

    // Abort an ADD at DECODE, EXEC or WB; WB must never be reached as a pulse after reset.
    task automatic test_reset_mid();
        logic [33:0] e, o;
        for (int abort_at = 1; abort_at <= 3; abort_at++) begin
            run_instr(9'b010_011_100, 0, 1'b0, "pre_abort");
            mem_ack   = 1'b1;
            mem_rdata = 9'b001_101_110;
            @(negedge clk);
            mem_ack = 1'b0;
            for (int k = 1; k < abort_at; k++) @(negedge clk);
            do_reset("abort");
            for (int k = 0; k < 2; k++) begin
                e = expect_vec(1'b1, 1'b0, 1'b0);
                o = observe();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL abort%0d idle%0d: got %h expected %h", abort_at, k, o, e);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_jnz();
        test_wait_states();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
